// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle datapath and its controller.
// master: datapath side (drives status/handshake inputs of the controller).
// slave:  controller side.
interface multicycle_controller_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned CNTW = 16
);
  logic            Start;
  logic [OPW-1:0]  Op_Code;
  logic            Zero;
  logic            Mem_Ready;
  logic            Mem_Req;
  logic            Mem_Write;
  logic            IR_Write;
  logic            PC_Write;
  logic [1:0]      PC_Src;
  logic            Reg_Write;
  logic            Mem_To_Reg;
  logic [2:0]      ALU_Op;
  logic            Halted;
  logic            Error;
  logic [2:0]      State;
  logic [CNTW-1:0] Instr_Count;

  modport master (
    output Start, Op_Code, Zero, Mem_Ready,
    input  Mem_Req, Mem_Write, IR_Write, PC_Write, PC_Src, Reg_Write, Mem_To_Reg,
    input  ALU_Op, Halted, Error, State, Instr_Count
  );

  modport slave (
    input  Start, Op_Code, Zero, Mem_Ready,
    output Mem_Req, Mem_Write, IR_Write, PC_Write, PC_Src, Reg_Write, Mem_To_Reg,
    output ALU_Op, Halted, Error, State, Instr_Count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing with a
// memory-wait timeout, sticky error state and a retired-instruction counter.
// Level outputs (Mem_Req, ALU_Op, ...) are registered from the next state; the
// strobes that must react to Mem_Ready/Zero in the same cycle are decoded.
module multicycle_controller #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.slave ctrl_io
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StErr    = 3'd7
  } state_e;

  localparam int unsigned      WaitW    = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  localparam logic [OPW-1:0] OpLoad   = OPW'(4'b1000);
  localparam logic [OPW-1:0] OpBranch = OPW'(4'b1001);
  localparam logic [OPW-1:0] OpStore  = OPW'(4'b1010);
  localparam logic [OPW-1:0] OpJump   = OPW'(4'b1110);
  localparam logic [OPW-1:0] OpHalt   = OPW'(4'b1111);

  function automatic logic [2:0] alu_map(input logic [OPW-1:0] op);
    logic [2:0] alu;
    case (op)
      OPW'(4'b0010): alu = 3'd2;
      OPW'(4'b0100): alu = 3'd6;
      OPW'(4'b0101): alu = 3'd3;
      OPW'(4'b0110): alu = 3'd5;
      OPW'(4'b1011): alu = 3'd0;
      OPW'(4'b1100): alu = 3'd4;
      OPW'(4'b1101): alu = 3'd7;
      default:       alu = 3'd1;
    endcase
    return alu;
  endfunction

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            retire;
  logic            ir_write, pc_write;
  logic [1:0]      pc_src;
  logic            op_upper_nz;

  logic       mem_req_q, mem_req_d;
  logic       mem_write_q, mem_write_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       halted_q, halted_d;
  logic       error_q, error_d;

  // Opcodes wider than the 4-bit base set are illegal when any extension bit is set.
  if (OPW > 4) begin : g_upper
    assign op_upper_nz = |ctrl_io.Op_Code[OPW-1:4];
  end else begin : g_no_upper
    assign op_upper_nz = 1'b0;
  end

  // Next-state, wait counter, retirement and same-cycle strobes.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = '0;
    retire   = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_io.Start) state_d = StFetch;
      end
      StFetch: begin
        if (ctrl_io.Mem_Ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        op_d = ctrl_io.Op_Code;
        if (ctrl_io.Op_Code == OpHalt) begin
          state_d = StHalt;
          retire  = 1'b1;
        end else if (op_upper_nz) begin
          state_d = StErr;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q == OpBranch) begin
          if (ctrl_io.Zero) begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
          end
          state_d = StFetch;
          retire  = 1'b1;
        end else if (op_q == OpJump) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = StFetch;
          retire   = 1'b1;
        end else if (op_q == OpLoad || op_q == OpStore) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (ctrl_io.Mem_Ready) begin
          if (op_q == OpStore) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt: begin
        if (ctrl_io.Start) state_d = StFetch;
      end
      StErr: begin
        state_d = StErr;
      end
    endcase
    cnt_d = cnt_q + CNTW'(retire);
  end

  // Level outputs for the state being entered, so they are valid from its first cycle.
  always_comb begin
    mem_req_d    = (state_d == StFetch) || (state_d == StMem);
    mem_write_d  = (state_d == StMem) && (op_d == OpStore);
    reg_write_d  = (state_d == StWb);
    mem_to_reg_d = (state_d == StWb) && (op_d == OpLoad);
    alu_op_d     = (state_d == StExec || state_d == StWb) ? alu_map(op_d) : 3'd0;
    halted_d     = (state_d == StHalt);
    error_d      = (state_d == StErr);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      wait_q       <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= 3'd0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wait_q       <= wait_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_op_q     <= alu_op_d;
      halted_q     <= halted_d;
      error_q      <= error_d;
    end
  end

  assign ctrl_io.Mem_Req     = mem_req_q;
  assign ctrl_io.Mem_Write   = mem_write_q;
  assign ctrl_io.IR_Write    = ir_write;
  assign ctrl_io.PC_Write    = pc_write;
  assign ctrl_io.PC_Src      = pc_src;
  assign ctrl_io.Reg_Write   = reg_write_q;
  assign ctrl_io.Mem_To_Reg  = mem_to_reg_q;
  assign ctrl_io.ALU_Op      = alu_op_q;
  assign ctrl_io.Halted      = halted_q;
  assign ctrl_io.Error       = error_q;
  assign ctrl_io.State       = state_q;
  assign ctrl_io.Instr_Count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level program model
// pushes the expected per-cycle outputs; a monitor pops and compares at negedge.
module tb_multicycle_controller;
  localparam int unsigned OPW     = 5;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNTW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OPW(OPW), .CNTW(CNTW)) bus ();

  multicycle_controller #(.OPW(OPW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_io (bus)
  );

  typedef struct packed {
    logic            mreq;
    logic            mwr;
    logic            irw;
    logic            pcw;
    logic [1:0]      pcsrc;
    logic            rw;
    logic            m2r;
    logic [2:0]      alu;
    logic            halted;
    logic            err;
    logic [2:0]      st;
    logic [CNTW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt   = 0;  // retired instructions since reset (model)

  int         dir_fw[9] = '{2, 0, 1, 0, 0, 0, 0, 15, 16};
  logic [4:0] dir_op[9] = '{5'h02, 5'h08, 5'h0A, 5'h09, 5'h09, 5'h0E, 5'h0F, 5'h0D, 5'h00};
  logic       dir_z[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [2:0] alu_of(input logic [3:0] o);
    case (o)
      4'h2:    return 3'd2;
      4'h4:    return 3'd6;
      4'h5:    return 3'd3;
      4'h6:    return 3'd5;
      4'hB:    return 3'd0;
      4'hC:    return 3'd4;
      4'hD:    return 3'd7;
      default: return 3'd1;
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.mreq   = bus.Mem_Req;
    o.mwr    = bus.Mem_Write;
    o.irw    = bus.IR_Write;
    o.pcw    = bus.PC_Write;
    o.pcsrc  = bus.PC_Src;
    o.rw     = bus.Reg_Write;
    o.m2r    = bus.Mem_To_Reg;
    o.alu    = bus.ALU_Op;
    o.halted = bus.Halted;
    o.err    = bus.Error;
    o.st     = bus.State;
    o.cnt    = bus.Instr_Count;
    return o;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.cnt = cnt[CNTW-1:0];
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [OPW-1:0] rop();
    return OPW'($urandom);
  endfunction

  function automatic int pick_waits();
    int r;
    r = int'($urandom_range(0, 59));
    if (r == 0) return TIMEOUT;
    if (r == 1) return TIMEOUT - 1;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [OPW-1:0] pick_op();
    if ($urandom_range(0, 39) == 0) return OPW'(16 + $urandom_range(0, 14));
    return OPW'($urandom_range(0, 15));
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h (state %0d cnt %0d) want %h (state %0d cnt %0d)",
               name, act, act.st, act.cnt, want, want.st, want.cnt);
    end
  endtask

  // One clock cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input logic s, input logic [OPW-1:0] o, input logic z, input logic r,
                     input obs_t e);
    @(posedge clk);
    #1;
    bus.Start     = s;
    bus.Op_Code   = o;
    bus.Zero      = z;
    bus.Mem_Ready = r;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.Start = 1'b0;
    #1;
    cnt = 0;
    chk("reset_async", sample(), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_up();
    repeat ($urandom_range(1, 2)) cyc(1'b0, rop(), rb(), rb(), base(3'd0));
    cyc(1'b1, rop(), rb(), rb(), base(3'd0));
  endtask

  // Cycles spent waiting for Mem_Ready; 'to' reports the access timed out.
  task automatic access(input logic [2:0] st, input logic wr, input int waits, output bit to);
    obs_t e;
    for (int i = 0; i < waits && i < TIMEOUT; i++) begin
      e      = base(st);
      e.mreq = 1'b1;
      e.mwr  = wr;
      cyc(rb(), rop(), rb(), 1'b0, e);
    end
    to = (waits >= TIMEOUT);
  endtask

  task automatic run_fetch(input int waits, output bit stop);
    obs_t e;
    bit   to;
    access(3'd1, 1'b0, waits, to);
    stop = to;
    if (to) return;
    e      = base(3'd1);
    e.mreq = 1'b1;
    e.irw  = 1'b1;
    e.pcw  = 1'b1;
    cyc(rb(), rop(), rb(), 1'b1, e);
  endtask

  // Decode onward for one instruction; 'stop' means the controller entered ERR.
  task automatic run_instr(input logic [OPW-1:0] opc, input logic z, input int mw,
                           output bit stop);
    obs_t       e;
    bit         to;
    logic [3:0] lo;
    stop = 1'b0;
    lo   = opc[3:0];
    cyc(rb(), opc, rb(), rb(), base(3'd2));
    if (opc[OPW-1:4] != '0) begin
      stop = 1'b1;
      return;
    end
    if (lo == 4'hF) begin
      cnt++;
      e        = base(3'd6);
      e.halted = 1'b1;
      repeat ($urandom_range(0, 2)) cyc(1'b0, rop(), rb(), rb(), e);
      cyc(1'b1, rop(), rb(), rb(), e);
      return;
    end
    e     = base(3'd3);
    e.alu = alu_of(lo);
    if (lo == 4'h9) begin
      e.pcw   = z;
      e.pcsrc = z ? 2'd1 : 2'd0;
      cyc(rb(), rop(), z, rb(), e);
      cnt++;
      return;
    end
    if (lo == 4'hE) begin
      e.pcw   = 1'b1;
      e.pcsrc = 2'd2;
      cyc(rb(), rop(), rb(), rb(), e);
      cnt++;
      return;
    end
    cyc(rb(), rop(), rb(), rb(), e);
    if (lo == 4'h8 || lo == 4'hA) begin
      access(3'd4, lo == 4'hA, mw, to);
      if (to) begin
        stop = 1'b1;
        return;
      end
      e      = base(3'd4);
      e.mreq = 1'b1;
      e.mwr  = (lo == 4'hA);
      cyc(rb(), rop(), rb(), 1'b1, e);
      if (lo == 4'hA) begin
        cnt++;
        return;
      end
    end
    e     = base(3'd5);
    e.rw  = 1'b1;
    e.m2r = (lo == 4'h8);
    e.alu = alu_of(lo);
    cyc(rb(), rop(), rb(), rb(), e);
    cnt++;
  endtask

  task automatic err_cycles(input int n);
    obs_t e;
    e     = base(3'd7);
    e.err = 1'b1;
    for (int i = 0; i < n; i++) cyc((i == 0) ? 1'b1 : rb(), rop(), rb(), rb(), e);
  endtask

  task automatic mid_mem_reset();
    obs_t e;
    bit   stop;
    do_reset();
    start_up();
    run_fetch(0, stop);
    cyc(rb(), OPW'(8), rb(), rb(), base(3'd2));
    e     = base(3'd3);
    e.alu = alu_of(4'h8);
    cyc(rb(), rop(), rb(), rb(), e);
    e      = base(3'd4);
    e.mreq = 1'b1;
    cyc(rb(), rop(), rb(), 1'b0, e);
    @(posedge clk);
    #1;
    bus.Mem_Ready = 1'b0;
    bus.Start     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    cnt = 0;
    chk("mid_mem_reset", sample(), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, rop(), rb(), rb(), base(3'd0));
  endtask

  // Monitor: compares DUT outputs against the oldest pending expectation.
  initial begin
    obs_t want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        chk($sformatf("cycle_state%0d", want.st), sample(), want);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit stop;
    bus.Start     = 1'b0;
    bus.Op_Code   = '0;
    bus.Zero      = 1'b0;
    bus.Mem_Ready = 1'b0;

    // Directed program: ALU op, load, store, branch taken/not, jump, halt,
    // fetch completing in the last allowed cycle, then a fetch timeout.
    stop = 1'b0;
    do_reset();
    start_up();
    for (int i = 0; i < 9; i++) begin
      run_fetch(dir_fw[i], stop);
      if (stop) break;
      run_instr(dir_op[i], dir_z[i], 1, stop);
      if (stop) break;
    end
    if (stop) err_cycles(4);

    // Illegal extension bits go straight to ERR.
    do_reset();
    start_up();
    run_fetch(0, stop);
    run_instr(OPW'(5'h13), 1'b0, 0, stop);
    if (stop) err_cycles(3);

    mid_mem_reset();

    // Randomized programs.
    for (int s = 0; s < 8; s++) begin
      stop = 1'b0;
      do_reset();
      start_up();
      for (int i = 0; i < 40; i++) begin
        run_fetch(pick_waits(), stop);
        if (stop) break;
        run_instr(pick_op(), rb(), pick_waits(), stop);
        if (stop) break;
      end
      if (stop) err_cycles(2);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
